// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear stopwatch on 1 ms ticks, falling-edge clocked.
// Optional lap-freeze display is enabled by defining STOPWATCH_LAP_FREEZE_EN.
module stopwatch_ctrl #(
    parameter int unsigned MS_MAX  = 999,
    parameter int unsigned SEC_MAX = 59,
    parameter int unsigned MIN_MAX = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ms_passed,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [9:0] ms_o,
    output logic [5:0] sec_o,
    output logic [6:0] min_o,
    output logic       running,
    output logic       ovf,
    output logic       lap_active
);
    localparam logic [9:0] MS_LIM  = MS_MAX[9:0];
    localparam logic [5:0] SEC_LIM = SEC_MAX[5:0];
    localparam logic [6:0] MIN_LIM = MIN_MAX[6:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [9:0] ms_q, ms_d;
    logic [5:0] sec_q, sec_d;
    logic [6:0] min_q, min_d;
    logic       ovf_q, ovf_d;
    logic       run_q, run_d;
    logic       at_max;

    assign at_max = (ms_q == MS_LIM) && (sec_q == SEC_LIM)
                 && (min_q == MIN_LIM);

    // Next state, live counters and overflow flag
    always_comb begin
        state_d = state_q;
        ms_d    = ms_q;
        sec_d   = sec_q;
        min_d   = min_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_RUN: begin
                if (ms_passed) begin
                    if (at_max) begin
                        ovf_d   = 1'b1;
                        state_d = S_PAUSE;
                    end else if (ms_q != MS_LIM) begin
                        ms_d = ms_q + 10'd1;
                    end else begin
                        ms_d = '0;
                        if (sec_q != SEC_LIM) begin
                            sec_d = sec_q + 6'd1;
                        end else begin
                            sec_d = '0;
                            min_d = min_q + 7'd1;
                        end
                    end
                end
                if (start_stop) begin
                    state_d = S_PAUSE;
                end
            end
            S_IDLE, S_PAUSE: begin
                if (clear) begin
                    state_d = S_IDLE;
                    ms_d    = '0;
                    sec_d   = '0;
                    min_d   = '0;
                    ovf_d   = 1'b0;
                end else if (start_stop && !ovf_q) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        run_d = (state_d == S_RUN);
    end

    // State and live counter registers
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ms_q    <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            ovf_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ms_q    <= ms_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            ovf_q   <= ovf_d;
            run_q   <= run_d;
        end
    end

    assign running = run_q;
    assign ovf     = ovf_q;

`ifdef STOPWATCH_LAP_FREEZE_EN
    logic       lap_q, lap_d;
    logic       cap;
    logic [9:0] dms_q, dms_d;
    logic [5:0] dsec_q, dsec_d;
    logic [6:0] dmin_q, dmin_d;

    // Lap flag and display: capture next live time, hold while frozen
    always_comb begin
        lap_d = lap_q;
        cap   = 1'b0;
        if (state_q == S_RUN) begin
            if (start_stop) begin
                lap_d = 1'b0;
            end else if (lap) begin
                lap_d = 1'b1;
                cap   = 1'b1;
            end
        end else if (clear) begin
            lap_d = 1'b0;
        end
        if (lap_d && !cap) begin
            dms_d  = dms_q;
            dsec_d = dsec_q;
            dmin_d = dmin_q;
        end else begin
            dms_d  = ms_d;
            dsec_d = sec_d;
            dmin_d = min_d;
        end
    end

    // Lap flag and display registers
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            lap_q  <= 1'b0;
            dms_q  <= '0;
            dsec_q <= '0;
            dmin_q <= '0;
        end else begin
            lap_q  <= lap_d;
            dms_q  <= dms_d;
            dsec_q <= dsec_d;
            dmin_q <= dmin_d;
        end
    end

    assign ms_o       = dms_q;
    assign sec_o      = dsec_q;
    assign min_o      = dmin_q;
    assign lap_active = lap_q;
`else
    logic unused_lap;
    assign unused_lap = lap;

    assign ms_o       = ms_q;
    assign sec_o      = sec_q;
    assign min_o      = min_q;
    assign lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard bench for stopwatch_ctrl.
// Small SEC/MIN limits keep the saturation run short.
module tb_stopwatch_ctrl;
    localparam int MSM  = 999;
    localparam int SCM  = 5;
    localparam int MNM  = 2;
    localparam int TMAX = (MNM + 1) * (SCM + 1) * (MSM + 1) - 1;
`ifdef STOPWATCH_LAP_FREEZE_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic       clk = 1'b1;
    logic       rst = 1'b0;
    logic       ms_passed = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic [9:0] ms_o;
    logic [5:0] sec_o;
    logic [6:0] min_o;
    logic       running;
    logic       ovf;
    logic       lap_active;

    stopwatch_ctrl #(
        .MS_MAX (MSM),
        .SEC_MAX(SCM),
        .MIN_MAX(MNM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ms_passed (ms_passed),
        .start_stop(start_stop),
        .clear     (clear),
        .lap       (lap),
        .ms_o      (ms_o),
        .sec_o     (sec_o),
        .min_o     (min_o),
        .running   (running),
        .ovf       (ovf),
        .lap_active(lap_active)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [25:0] sb_q[$];

    // reference model: linear ms count, st 0=idle 1=run 2=pause
    int m_st, m_t, m_lt;
    bit m_ovf, m_lap;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] dut_pack();
        return {min_o, sec_o, ms_o, running, ovf, lap_active};
    endfunction

    function automatic logic [25:0] exp_pack();
        int d;
        d = m_lap ? m_lt : m_t;
        return {7'(d / ((SCM + 1) * (MSM + 1))),
                6'((d / (MSM + 1)) % (SCM + 1)),
                10'(d % (MSM + 1)),
                m_st == 1, m_ovf, m_lap};
    endfunction

    task automatic mreset();
        m_st  = 0;
        m_t   = 0;
        m_lt  = 0;
        m_ovf = 1'b0;
        m_lap = 1'b0;
    endtask

    task automatic model(input bit tk, input bit ss, input bit cl,
                         input bit lp);
        if (m_st == 1) begin
            if (tk) begin
                if (m_t == TMAX) begin
                    m_ovf = 1'b1;
                    m_st  = 2;
                end else begin
                    m_t++;
                end
            end
            if (ss) begin
                m_st  = 2;
                m_lap = 1'b0;
            end else if (lp && LAP_EN) begin
                m_lap = 1'b1;
                m_lt  = m_t;
            end
        end else if (cl) begin
            m_st  = 0;
            m_t   = 0;
            m_ovf = 1'b0;
            m_lap = 1'b0;
        end else if (ss && !m_ovf) begin
            m_st = 1;
        end
    endtask

    // one falling-edge cycle: drive, predict, then compare
    task automatic cyc(input bit tk, input bit ss, input bit cl,
                       input bit lp);
        @(posedge clk);
        ms_passed  = tk;
        start_stop = ss;
        clear      = cl;
        lap        = lp;
        model(tk, ss, cl, lp);
        sb_q.push_back(exp_pack());
        @(negedge clk);
        #1;
        if (sb_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
        else check("sb", 32'(dut_pack()), 32'(sb_q.pop_front()));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mreset();
        #1 rst = 1'b1;
        #3;
        check("rst_out", 32'(dut_pack()), 32'd0);
        @(posedge clk);
        rst = 1'b0;

        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(1000);
        check("k_ms", 32'(ms_o), 32'd0);
        check("k_sec", 32'(sec_o), 32'd1);
        check("k_min", 32'(min_o), 32'd0);
        check("k_run", 32'(running), 32'd1);

        ticks(1500);
        check("c_sec", 32'(sec_o), 32'd2);
        check("c_ms", 32'(ms_o), 32'd500);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("c_ign_ms", 32'(ms_o), 32'd501);
        check("c_ign_run", 32'(running), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check("cs_time", 32'({min_o, sec_o, ms_o}), 32'd0);
        check("cs_run", 32'(running), 32'd0);

        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(2);
        check("p_ms", 32'(ms_o), 32'd7);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("tp_ms", 32'(ms_o), 32'd8);
        check("tp_run", 32'(running), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("ti_ms", 32'(ms_o), 32'd0);
        check("ti_run", 32'(running), 32'd1);
        ticks(1);
        check("ti_ms1", 32'(ms_o), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(1200);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(300);
        check("l_ms", 32'(ms_o), LAP_EN ? 32'd200 : 32'd500);
        check("l_sec", 32'(sec_o), 32'd1);
        check("l_act", 32'(lap_active), 32'(LAP_EN));
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("lp_ms", 32'(ms_o), 32'd500);
        check("lp_act", 32'(lap_active), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        @(posedge clk);
        ms_passed  = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        rst        = 1'b1;
        #1;
        check("rst_mid", 32'(dut_pack()), 32'd0);
        mreset();
        @(posedge clk);
        rst = 1'b0;

        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(TMAX);
        check("s_top", 32'({min_o, sec_o, ms_o}),
              32'({7'(MNM), 6'(SCM), 10'(MSM)}));
        ticks(1);
        check("s_hold", 32'({min_o, sec_o, ms_o}),
              32'({7'(MNM), 6'(SCM), 10'(MSM)}));
        check("s_ovf", 32'(ovf), 32'd1);
        check("s_run", 32'(running), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("s_ss_ign", 32'(running), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("s_clr", 32'(dut_pack()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Run/pause/clear stopwatch that sits directly downstream of the 1 ms tick generator. It consumes the single-cycle `ms_passed` tick and accumulates elapsed time as milliseconds, seconds and minutes. Presented time is registered and drives the display/readout stage.

## Interface
Parameters:
- `MS_MAX`, 999, last millisecond value before wrap into seconds
- `SEC_MAX`, 59, last second value before wrap into minutes
- `MIN_MAX`, 99, last minute value; saturation point

Ports:
- `clk` input 1: system clock; all state updates on the falling edge (same edge as the tick source)
- `rst` input 1: asynchronous, active-high reset
- `ms_passed` input 1: 1 ms tick from the tick generator, high for exactly one clk period
- `start_stop` input 1: single-cycle command pulse; toggles run/pause
- `clear` input 1: single-cycle command pulse; zero time
- `lap` input 1: single-cycle lap pulse (see Configuration)
- `ms_o` output 10: displayed milliseconds, 0..MS_MAX
- `sec_o` output 6: displayed seconds, 0..SEC_MAX
- `min_o` output 7: displayed minutes, 0..MIN_MAX
- `running` output 1: high in RUN
- `ovf` output 1: sticky saturation flag
- `lap_active` output 1: display frozen on lap value

## Operation
- Reset: state IDLE. Counters, display, `running`, `ovf` and `lap_active` are all 0.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE --start_stop--> RUN.
  - RUN --start_stop--> PAUSE.
  - PAUSE --start_stop--> RUN.
  - PAUSE or IDLE --clear--> IDLE with counters zeroed.
  - RUN --saturation--> PAUSE.
- `clear` while in RUN is ignored.
- `clear` and `start_stop` in the same cycle:
  - In IDLE or PAUSE, `clear` wins: zero the counters, go to IDLE, ignore the start.
  - In RUN, `clear` is ignored and `start_stop` pauses.
- Counting: every clk cycle where `ms_passed` = 1 and the current state is RUN:
  - Increment ms.
  - When ms = MS_MAX: ms → 0 and sec increments.
  - When sec = SEC_MAX: sec → 0 and min increments.
- Saturation: a tick at MIN_MAX:SEC_MAX:MS_MAX leaves the counters unchanged, sets `ovf` = 1 and forces PAUSE.
- While `ovf` = 1, `start_stop` is ignored. Only `clear` or `rst` releases `ovf`.
- A tick seen in IDLE or PAUSE is dropped. Ticks are never queued.
- Arithmetic is unsigned binary. Counters never hold values above their MAX.

## Timing
- All outputs are registered. Command and tick effects become visible after the falling edge that samples them.
- A `start_stop` sampled at edge N sets `running` = 1 after edge N. A tick sampled at edge N is not counted, because the state was IDLE at that edge. The first counted tick is at edge ≥ N+1.
- A pause at edge N that coincides with a tick: the tick is counted, because the state was RUN at that edge.
- Tick-to-display latency is 1 edge, except when the display is frozen by lap.
- Reset mid-count: outputs go to 0 asynchronously on `rst` rising. Operation resumes on the first falling edge after `rst` deasserts.

## Configuration
- Macro: `STOPWATCH_LAP_FREEZE_EN`.
- Defined:
  - A `lap` pulse in RUN copies the live counters into the display registers and sets `lap_active` = 1. The display holds while counting continues.
  - Another `lap` pulse in RUN re-captures the current live time.
  - `start_stop` to PAUSE, `clear`, or `rst` drops `lap_active` to 0, and the display tracks the live counters again.
  - `lap` outside RUN is ignored.
- Undefined:
  - The `lap` input is ignored.
  - `lap_active` is tied to 0.
  - The display always equals the live counters.

## Test plan
- Reset then `start_stop`, then 1000 ticks → after the 1000th tick, `ms_o` = 0, `sec_o` = 1, `min_o` = 0, `running` = 1.
- Start, 5 ticks, `start_stop`, 3 ticks, `start_stop`, 2 ticks → `ms_o` = 7; the 3 ticks during pause are dropped.
- Preload by running to 99:59.999, then 1 more tick → time is unchanged, `ovf` = 1, `running` = 0. A further `start_stop` is ignored. `clear` → all 0, `ovf` = 0.
- `clear` pulse during RUN at 0:02.500 → ignored, counting continues. `clear` together with `start_stop` in PAUSE → IDLE, time 0, `running` = 0.
- Tick and `start_stop` in the same cycle, from IDLE → tick dropped. From RUN → tick counted, then pause.
- With `STOPWATCH_LAP_FREEZE_EN`: `lap` at 0:01.200, then 300 ticks → display 0:01.200 and `lap_active` = 1. `start_stop` → display 0:01.500 and `lap_active` = 0. Assert `rst` mid-run → all outputs 0 immediately.
